// File: rtl/line_read_extract_pkg.sv
// Shared types and geometry for the line-buffered read extractor.
package line_read_extract_pkg;

   localparam int LINE_WIDTH  = 128;
   localparam int OFFSET_BITS = 4;
   localparam int TAG_BITS    = 12;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_RESPOND = 2'd2
   } state_t;

endpackage

// File: rtl/line_read_extract_line_select.sv
// Combinational word/byte extraction from a 128-bit cache line.
module line_select
   import line_read_extract_pkg::*;
(
   input  logic [LINE_WIDTH-1:0]  i_line,
   input  logic [OFFSET_BITS-1:0] i_offset,
   input  logic [1:0]             i_byte_enable,
   output logic [15:0]            o_data
);

   // Bit positions of the addressed halfword (offset[0] dropped) and byte.
   logic [6:0] w_word_lsb;
   logic [6:0] w_byte_lsb;

   assign w_word_lsb = {i_offset[3:1], 4'h0};
   assign w_byte_lsb = {i_offset, 3'b000};

   // Word read for 2'b11, otherwise a zero-extended byte.
   always_comb begin
      o_data = 16'h0000;
      if (i_byte_enable == 2'b11) begin
         o_data = i_line[w_word_lsb +: 16];
      end else begin
         o_data = {8'h00, i_line[w_byte_lsb +: 8]};
      end
   end

endmodule

// File: rtl/line_read_extract.sv
// One-entry line buffer in front of a line-wide cache; serves 16-bit/8-bit CPU reads.
module line_read_extract
   import line_read_extract_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  cpu_read,
   input  logic [15:0]           cpu_address,
   input  logic [1:0]            byte_enable,
   input  logic                  invalidate,
   output logic [15:0]           cpu_rdata,
   output logic                  cpu_resp,
   output logic                  line_read,
   output logic [15:0]           line_address,
   input  logic [LINE_WIDTH-1:0] line_rdata,
   input  logic                  line_resp
);

   state_t                  r_state;
   state_t                  w_next;
   logic                    r_valid;
   logic [TAG_BITS-1:0]     r_tag;
   logic [LINE_WIDTH-1:0]   r_buf;
   logic [15:0]             r_addr;
   logic [1:0]              r_be;
   logic                    w_hit;
   logic [15:0]             w_sel_data;

   // A same-cycle invalidate must not let a stale line count as a hit.
   assign w_hit = r_valid && (r_tag == cpu_address[15:OFFSET_BITS]) && !invalidate;

   line_select u_line_select (
      .i_line        (r_buf),
      .i_offset      (r_addr[OFFSET_BITS-1:0]),
      .i_byte_enable (r_be),
      .o_data        (w_sel_data)
   );

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   // Request latch and line buffer; invalidate wins over a coincident fill.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= 1'b0;
         r_tag   <= '0;
         r_buf   <= '0;
         r_addr  <= 16'h0000;
         r_be    <= 2'b00;
      end else begin
         if (r_state == ST_IDLE && cpu_read) begin
            r_addr <= cpu_address;
            r_be   <= byte_enable;
         end
         if (r_state == ST_FETCH && line_resp) begin
            r_buf   <= line_rdata;
            r_tag   <= r_addr[15:OFFSET_BITS];
            r_valid <= 1'b1;
         end
         if (invalidate) r_valid <= 1'b0;
      end
   end

   // Next state and outputs; everything idles at zero outside its active state.
   always_comb begin
      w_next       = r_state;
      cpu_resp     = 1'b0;
      cpu_rdata    = 16'h0000;
      line_read    = 1'b0;
      line_address = 16'h0000;
      case (r_state)
         ST_IDLE: begin
            if (cpu_read) w_next = w_hit ? ST_RESPOND : ST_FETCH;
         end
         ST_FETCH: begin
            line_read    = 1'b1;
            line_address = {r_addr[15:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            if (line_resp) w_next = ST_RESPOND;
         end
         ST_RESPOND: begin
            cpu_resp  = 1'b1;
            cpu_rdata = w_sel_data;
            w_next    = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_line_read_extract.sv
// Scoreboard bench: stimulus pushes expected read data, a monitor pops on cpu_resp.
module tb_line_read_extract;

   localparam logic [127:0] L = 128'hFFEE_DDCC_BBAA_9988_7766_5544_3322_1100;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         cpu_read;
   logic [15:0]  cpu_address;
   logic [1:0]   byte_enable;
   logic         invalidate;
   logic [15:0]  cpu_rdata;
   logic         cpu_resp;
   logic         line_read;
   logic [15:0]  line_address;
   logic [127:0] line_rdata;
   logic         line_resp;

   int n_checks = 0;
   int n_fail   = 0;
   logic [15:0] exp_q[$];

   line_read_extract dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .cpu_read     (cpu_read),
      .cpu_address  (cpu_address),
      .byte_enable  (byte_enable),
      .invalidate   (invalidate),
      .cpu_rdata    (cpu_rdata),
      .cpu_resp     (cpu_resp),
      .line_read    (line_read),
      .line_address (line_address),
      .line_rdata   (line_rdata),
      .line_resp    (line_resp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every response pops one expected value; idle data must be zero.
   always @(negedge clk) begin
      if (cpu_resp === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_resp", 32'd1, 32'd0);
         end else begin
            chk("cpu_rdata", {16'h0, cpu_rdata}, {16'h0, exp_q.pop_front()});
         end
      end else begin
         chk("idle_rdata", {16'h0, cpu_rdata}, 32'h0);
      end
   end

   // Issue one read; entered and left on a falling edge.
   task automatic do_read(input logic [15:0] addr, input logic [1:0] be, input bit miss,
                          input int delay, input bit inv_on_resp, input bit drop_early,
                          input logic [15:0] exp_la, input logic [15:0] exp_data);
      cpu_read    = 1'b1;
      cpu_address = addr;
      byte_enable = be;
      exp_q.push_back(exp_data);
      @(negedge clk);
      if (miss) begin
         chk("miss_line_read", {31'h0, line_read}, 32'd1);
         chk("line_address", {16'h0, line_address}, {16'h0, exp_la});
         if (drop_early) cpu_read = 1'b0;
         repeat (delay) begin
            @(negedge clk);
            chk("fetch_line_read", {31'h0, line_read}, 32'd1);
         end
         line_resp  = 1'b1;
         line_rdata = L;
         invalidate = inv_on_resp;
         @(negedge clk);
         line_resp  = 1'b0;
         line_rdata = '0;
         invalidate = 1'b0;
      end
      chk("resp_latency", {31'h0, cpu_resp}, 32'd1);
      chk("resp_no_line_read", {31'h0, line_read}, 32'd0);
      cpu_read = 1'b0;
      @(negedge clk);
      chk("resp_one_cycle", {31'h0, cpu_resp}, 32'd0);
   endtask

   initial begin
      reset_n     = 1'b0;
      cpu_read    = 1'b0;
      cpu_address = 16'h0;
      byte_enable = 2'b00;
      invalidate  = 1'b0;
      line_rdata  = '0;
      line_resp   = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_cpu_resp", {31'h0, cpu_resp}, 32'd0);
      chk("rst_line_read", {31'h0, line_read}, 32'd0);
      chk("rst_line_address", {16'h0, line_address}, 32'h0);
      chk("rst_cpu_rdata", {16'h0, cpu_rdata}, 32'h0);
      reset_n = 1'b1;
      @(negedge clk);

      // Word miss, then byte/word hits on the same line.
      do_read(16'h1236, 2'b11, 1, 1, 0, 0, 16'h1230, 16'h7766);
      do_read(16'h123E, 2'b01, 0, 0, 0, 0, 16'h0000, 16'h00EE);
      do_read(16'h123F, 2'b01, 0, 0, 0, 0, 16'h0000, 16'h00FF);
      do_read(16'h1236, 2'b10, 0, 0, 0, 0, 16'h0000, 16'h0066);
      do_read(16'h1233, 2'b11, 0, 0, 0, 0, 16'h0000, 16'h3322);

      // Invalidate pulse forces a refetch of the same line.
      invalidate = 1'b1;
      @(negedge clk);
      invalidate = 1'b0;
      do_read(16'h1236, 2'b11, 1, 0, 0, 0, 16'h1230, 16'h7766);

      // Tag miss, with cpu_read dropped mid-fetch; then a hit ignoring addr[0].
      do_read(16'h1240, 2'b11, 1, 2, 0, 1, 16'h1240, 16'h1100);
      do_read(16'h1241, 2'b11, 0, 0, 0, 0, 16'h0000, 16'h1100);

      // Invalidate coincident with line_resp: data used, line not kept.
      do_read(16'h1236, 2'b11, 1, 1, 1, 0, 16'h1230, 16'h7766);
      do_read(16'h1236, 2'b11, 1, 0, 0, 0, 16'h1230, 16'h7766);

      // Reset while fetching drops line_read at once.
      cpu_read    = 1'b1;
      cpu_address = 16'h1250;
      byte_enable = 2'b11;
      @(negedge clk);
      chk("pre_rst_line_read", {31'h0, line_read}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("midfetch_rst_line_read", {31'h0, line_read}, 32'd0);
      chk("midfetch_rst_line_address", {16'h0, line_address}, 32'h0);
      chk("midfetch_rst_cpu_resp", {31'h0, cpu_resp}, 32'd0);
      cpu_read = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      do_read(16'h1236, 2'b11, 1, 0, 0, 0, 16'h1230, 16'h7766);

      repeat (2) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/line_read_extract.md
LINE_READ_EXTRACT -- requirements
Module: line_read_extract

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port cpu_read, input, 1, read request, held until cpu_resp.
REQ-004 SHALL have port cpu_address, input, 16, byte address of the read.
REQ-005 SHALL have port byte_enable, input, 2, 2'b11 = 16-bit word read, any other value = byte read.
REQ-006 SHALL have port invalidate, input, 1, clears the line buffer (pulsed on any cache write).
REQ-007 SHALL have port cpu_rdata, output, 16, extracted read data.
REQ-008 SHALL have port cpu_resp, output, 1, one-cycle completion pulse.
REQ-009 SHALL have port line_read, output, 1, line request to the cache.
REQ-010 SHALL have port line_address, output, 16, line-aligned address {addr_q[15:4],4'h0}.
REQ-011 SHALL have port line_rdata, input, 128, line returned by the cache.
REQ-012 SHALL have port line_resp, input, 1, cache response; line_rdata valid this cycle.

Function
REQ-013 SHALL hold a one-entry line buffer: 128-bit data, 12-bit tag (address[15:4]), valid bit.
REQ-014 SHALL implement FSM states IDLE, FETCH, RESPOND.
REQ-015 IDLE: on cpu_read, latch cpu_address and byte_enable into addr_q/be_q.
REQ-016 IDLE: hit (valid, tag == cpu_address[15:4], invalidate low) -> RESPOND; otherwise cpu_read -> FETCH.
REQ-017 FETCH: line_read = 1 every cycle; on line_resp, capture line_rdata and tag, set valid, -> RESPOND.
REQ-018 RESPOND: cpu_resp = 1 for exactly one cycle, then -> IDLE unconditionally.
REQ-019 Hit latency: request sampled in cycle N, cpu_resp in cycle N+1, no line_read.
REQ-020 Miss latency: line_read from N+1 through the line_resp cycle M, cpu_resp in M+1.
REQ-021 Word read: cpu_rdata = buffer[16*addr_q[3:1] +: 16]; addr_q[0] ignored.
REQ-022 Byte read: cpu_rdata = {8'h00, buffer[8*addr_q[3:0] +: 8]} (zero-extended).
REQ-023 cpu_rdata SHALL be 16'h0000 outside RESPOND; line_address 16'h0000 when line_read = 0.
REQ-024 invalidate clears valid in any state; if coincident with line_resp, data is captured and used for the current response but valid stays 0.
REQ-025 Deassertion of cpu_read during FETCH SHALL NOT abort; the fetch completes and cpu_resp pulses.
REQ-026 A new request in the cycle after cpu_resp SHALL be accepted (back-to-back, no bubble beyond IDLE).

Reset
REQ-027 reset_n low SHALL immediately force state IDLE, valid 0, tag 0, buffer 0, addr_q 0, be_q 0.
REQ-028 During reset: cpu_resp 0, cpu_rdata 16'h0000, line_read 0, line_address 16'h0000; a reset mid-FETCH drops line_read without waiting for line_resp.

Structure
REQ-029 A shared package SHALL hold the state enum, LINE_WIDTH = 128, OFFSET_BITS = 4, and TAG_BITS = 12.
REQ-030 Extraction SHALL be a combinational sub-module line_select (line, offset, byte_enable -> 16-bit data).

Verification
Line L = 128'hFFEE_DDCC_BBAA_9988_7766_5544_3322_1100 throughout.
REQ-031 Word miss: after reset, read 16'h1236, be 2'b11, line_resp L after 2 cycles -> line_address 16'h1230; cpu_resp next cycle with cpu_rdata 16'h7766.
REQ-032 Byte hit: then read 16'h123E, be 2'b01 -> no line_read; cpu_resp next cycle with 16'h00EE; 16'h123F -> 16'h00FF.
REQ-033 Tag miss: read 16'h1240 -> line_read with line_address 16'h1240.
REQ-034 Invalidate: pulse invalidate, re-read 16'h1236 -> line_read reasserted (miss).
REQ-035 Simultaneous events: invalidate coincident with line_resp -> response 16'h7766, and the next same-line read misses.
REQ-036 Reset mid-FETCH: reset_n low while line_read = 1 -> line_read 0 immediately; post-reset read of 16'h1236 misses.
